// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND column read path.
package nand_pkg;

  localparam int PAGE_BYTES = 2112;
  localparam int MAX_COL    = 2111;
  localparam int COL_W      = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_WAIT_WHR,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } col_rd_state_t;

  // Phase timer reload value: a phase of n cycles loads n-1 so tc lands on its last cycle.
  function automatic logic [7:0] phase_len_m1(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/nand_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module nand_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk2,
  input  logic         NReset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/nand_column_reader.sv
// Column read engine: two address cycles, tWHR wait, then one nRE strobe per byte
// from start_col to end_col inclusive.
module nand_column_reader #(
  parameter int COL_BITS = nand_pkg::COL_W,
  parameter int MAX_COL  = nand_pkg::MAX_COL,
  parameter int WE_LOW   = 2,
  parameter int WE_HIGH  = 1,
  parameter int RE_LOW   = 2,
  parameter int RE_HIGH  = 1,
  parameter int TWHR     = 4
) (
  input  logic                clk2,
  input  logic                NReset,
  input  logic                start,
  input  logic                abort,
  input  logic [COL_BITS-1:0] start_col,
  input  logic [COL_BITS-1:0] end_col,
  input  logic [7:0]          io_in,
  output logic [7:0]          io_out,
  output logic                io_oe,
  output logic                ale,
  output logic                nwe,
  output logic                nre,
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic [COL_BITS-1:0] cur_col,
  output logic                busy,
  output logic                done,
  output logic                err
);

  import nand_pkg::*;

  // state       | meaning
  // IDLE        | waiting for start
  // ADDR_LO     | ale high, nwe low, address byte on io_out
  // ADDR_HI     | nwe high, address byte held
  // WAIT_WHR    | bus released, tWHR before first nre fall
  // RD_LO       | nre low, byte captured on last cycle
  // RD_HI       | nre high, data_valid on first cycle
  // DONE        | one-cycle completion pulse

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(MAX_COL);

  col_rd_state_t       state;
  logic [COL_BITS-1:0] s_col;
  logic [COL_BITS-1:0] e_col;
  logic                idx;
  logic                tmr_load;
  logic [7:0]          tmr_val;
  logic                tmr_tc;

  nand_phase_timer #(.W(8)) u_timer (
    .clk2     (clk2),
    .NReset   (NReset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Reload on every phase boundary with the length of the phase being entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = 1'b1;
        tmr_val  = phase_len_m1(WE_LOW);
      end
      ST_ADDR_LO: begin
        tmr_load = tmr_tc;
        tmr_val  = phase_len_m1(WE_HIGH);
      end
      ST_ADDR_HI: begin
        tmr_load = tmr_tc;
        tmr_val  = idx ? phase_len_m1(TWHR) : phase_len_m1(WE_LOW);
      end
      ST_WAIT_WHR: begin
        tmr_load = tmr_tc;
        tmr_val  = phase_len_m1(RE_LOW);
      end
      ST_RD_LO: begin
        tmr_load = tmr_tc;
        tmr_val  = phase_len_m1(RE_HIGH);
      end
      ST_RD_HI: begin
        tmr_load = tmr_tc;
        tmr_val  = phase_len_m1(RE_LOW);
      end
      default: begin
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state      <= ST_IDLE;
      s_col      <= '0;
      e_col      <= '0;
      idx        <= 1'b0;
      io_out     <= '0;
      io_oe      <= 1'b0;
      ale        <= 1'b0;
      nwe        <= 1'b1;
      nre        <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      cur_col    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        ale   <= 1'b0;
        io_oe <= 1'b0;
        nwe   <= 1'b1;
        nre   <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              s_col <= start_col;
              e_col <= end_col;
              err   <= 1'b0;
              busy  <= 1'b1;
              if (start_col > end_col || end_col > LAST_COL) begin
                state <= ST_DONE;
                err   <= 1'b1;
                done  <= 1'b1;
              end else begin
                state  <= ST_ADDR_LO;
                idx    <= 1'b0;
                ale    <= 1'b1;
                io_oe  <= 1'b1;
                nwe    <= 1'b0;
                io_out <= start_col[7:0];
              end
            end
          end
          ST_ADDR_LO: begin
            if (tmr_tc) begin
              state <= ST_ADDR_HI;
              nwe   <= 1'b1;
            end
          end
          ST_ADDR_HI: begin
            if (tmr_tc) begin
              if (!idx) begin
                idx    <= 1'b1;
                state  <= ST_ADDR_LO;
                nwe    <= 1'b0;
                io_out <= 8'(s_col >> 8);
              end else begin
                state   <= ST_WAIT_WHR;
                ale     <= 1'b0;
                io_oe   <= 1'b0;
                cur_col <= s_col;
              end
            end
          end
          ST_WAIT_WHR: begin
            if (tmr_tc) begin
              state <= ST_RD_LO;
              nre   <= 1'b0;
            end
          end
          ST_RD_LO: begin
            if (tmr_tc) begin
              state      <= ST_RD_HI;
              nre        <= 1'b1;
              data_out   <= io_in;
              data_valid <= 1'b1;
            end
          end
          ST_RD_HI: begin
            if (tmr_tc) begin
              if (cur_col == e_col) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state   <= ST_RD_LO;
                nre     <= 1'b0;
                cur_col <= cur_col + COL_BITS'(1);
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            ale   <= 1'b0;
            io_oe <= 1'b0;
            nwe   <= 1'b1;
            nre   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_column_reader.sv
// Scoreboard bench: stimulus pushes expected address bytes, data bytes and done events;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_nand_column_reader;

  logic        clk2 = 1'b0;
  logic        NReset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] start_col = '0;
  logic [11:0] end_col = '0;
  logic [7:0]  io_in = '0;
  logic [7:0]  io_out;
  logic        io_oe, ale, nwe, nre;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [11:0] cur_col;
  logic        busy, done, err;

  nand_column_reader dut (
    .clk2       (clk2),
    .NReset     (NReset),
    .start      (start),
    .abort      (abort),
    .start_col  (start_col),
    .end_col    (end_col),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .ale        (ale),
    .nwe        (nwe),
    .nre        (nre),
    .data_out   (data_out),
    .data_valid (data_valid),
    .cur_col    (cur_col),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  typedef struct {logic [7:0] data; logic [11:0] col;} byte_t;
  typedef struct {int at; logic err;} done_t;

  byte_t      byte_q[$];
  logic [7:0] addr_q[$];
  done_t      done_q[$];

  int n_pass = 0;
  int n_total = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int strobe_bad = 0;
  bit strobe_watch = 1'b0;
  int start_cyc = 0;

  // NAND model: each nre fall presents io_base + (falls since run start).
  logic [7:0] io_base = '0;
  int nre_falls = 0;
  int fall_base = 0;
  always @(negedge nre) begin
    io_in = 8'(int'(io_base) + nre_falls - fall_base);
    nre_falls++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin : monitor
    logic prev_nwe;
    byte_t b;
    done_t d;
    logic [7:0] a;
    prev_nwe = 1'b1;
    forever begin
      @(negedge clk2);
      if (!NReset) begin
        prev_nwe = 1'b1;
      end else begin
        if (prev_nwe === 1'b0 && nwe === 1'b1) begin
          if (addr_q.size() == 0) chk("addr_unexpected", 1, 0);
          else begin
            a = addr_q.pop_front();
            chk("addr_byte", io_out, a);
            chk("addr_ale", {ale, io_oe}, 2'b11);
          end
        end
        prev_nwe = nwe;
        if (data_valid === 1'b1) begin
          valid_cnt++;
          if (byte_q.size() == 0) chk("data_unexpected", 1, 0);
          else begin
            b = byte_q.pop_front();
            chk("data_byte", data_out, b.data);
            chk("data_col", cur_col, b.col);
          end
        end
        if (done === 1'b1) begin
          done_cnt++;
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc - start_cyc, d.at - start_cyc);
            chk("done_err", err, d.err);
          end
        end
        if (strobe_watch && (nwe !== 1'b1 || nre !== 1'b1 || ale !== 1'b0)) strobe_bad++;
      end
    end
  end

  task automatic issue(input logic [11:0] sc, input logic [11:0] ec, input logic [7:0] base,
                       input int nbytes, input bit exp_done);
    @(posedge clk2); #1;
    start_col = sc;
    end_col   = ec;
    start     = 1'b1;
    start_cyc = cyc;
    io_base   = base;
    fall_base = nre_falls;
    if (sc > ec || ec > 12'd2111) begin
      if (exp_done) done_q.push_back('{cyc + 1, 1'b1});
    end else begin
      addr_q.push_back(sc[7:0]);
      addr_q.push_back({4'h0, sc[11:8]});
      for (int i = 0; i < nbytes; i++) byte_q.push_back('{8'(int'(base) + i), 12'(int'(sc) + i)});
      if (exp_done) done_q.push_back('{cyc + 11 + 3 * (int'(ec) - int'(sc) + 1), 1'b0});
    end
    @(posedge clk2); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(posedge clk2);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk2);
      if (busy === 1'b0) break;
    end
    #1;
    chk(name, busy, 0);
  endtask

  task automatic run(input logic [11:0] sc, input logic [11:0] ec, input logic [7:0] base,
                     input int budget);
    int v0, d0, n;
    v0 = valid_cnt;
    d0 = done_cnt;
    n = (sc > ec || ec > 12'd2111) ? 0 : int'(ec) - int'(sc) + 1;
    issue(sc, ec, base, n, 1'b1);
    wait_idle("run_idle", budget);
    chk("valid_count", valid_cnt - v0, n);
    chk("done_count", done_cnt - d0, 1);
    chk("queues_drained", byte_q.size() + addr_q.size() + done_q.size(), 0);
  endtask

  initial begin
    int v0, d0;
    repeat (3) @(posedge clk2);
    #1;
    chk("reset_ctrl", {io_out, io_oe, ale, nwe, nre, busy, done, err},
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_data", {data_out, data_valid, cur_col}, {8'h00, 1'b0, 12'h000});
    NReset = 1'b1;

    // Four bytes from column 0.
    run(12'd0, 12'd3, 8'hA0, 100);
    chk("err_after_good", err, 0);

    // Address straddling the high byte.
    run(12'h83A, 12'h83F, 8'h40, 100);

    // Range errors leave the strobes alone and hold err until the next good start.
    strobe_watch = 1'b1;
    run(12'd5, 12'd4, 8'h00, 20);
    chk("err_held_1", err, 1);
    run(12'd0, 12'd2112, 8'h00, 20);
    chk("err_held_2", err, 1);
    strobe_watch = 1'b0;
    chk("err_strobes_idle", strobe_bad, 0);
    issue(12'd2, 12'd2, 8'h55, 1, 1'b1);
    chk("err_cleared", err, 0);
    wait_idle("clr_idle", 100);

    // Abort during the second byte's RD_LO.
    v0 = valid_cnt;
    d0 = done_cnt;
    issue(12'd0, 12'd3, 8'hC0, 1, 1'b0);
    wait_cyc(start_cyc + 14);
    chk("abort_pre_nre", nre, 0);
    abort = 1'b1;
    @(posedge clk2); #1;
    abort = 1'b0;
    @(negedge clk2);
    chk("abort_idle", {busy, nre, nwe, ale, io_oe}, 5'b01100);
    repeat (20) @(negedge clk2);
    #1;
    chk("abort_valids", valid_cnt - v0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_drained", byte_q.size() + addr_q.size(), 0);

    // A start pulsed mid-read must not disturb the active run.
    v0 = valid_cnt;
    issue(12'd20, 12'd23, 8'h30, 4, 1'b1);
    wait_cyc(start_cyc + 15);
    start_col = 12'd100;
    end_col   = 12'd200;
    start     = 1'b1;
    @(posedge clk2); #1;
    start = 1'b0;
    wait_idle("midstart_idle", 100);
    chk("midstart_valids", valid_cnt - v0, 4);
    chk("midstart_drained", byte_q.size() + done_q.size(), 0);

    // Asynchronous reset during ADDR_LO.
    issue(12'd0, 12'd1, 8'h00, 2, 1'b1);
    @(posedge clk2); #1;
    chk("pre_rst_nwe", nwe, 0);
    NReset = 1'b0;
    #1;
    chk("rst_async", {nwe, ale, busy, io_oe}, 4'b1000);
    byte_q.delete();
    addr_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk2);
    #1;
    NReset = 1'b1;
    run(12'h83A, 12'h83F, 8'h70, 100);

    // Full page.
    run(12'd0, 12'd2111, 8'h00, 7000);
    chk("fullpage_last_col", cur_col, 12'd2111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
